seq_div: RTL and testbench
==========================

Name: seq_div

Overview:
- Multi-cycle unsigned restoring divider. It is the inverse companion of seq_mult: it recovers quotient and remainder from a product-style dividend.
- Computes one quotient bit per clock, MSB first, and uses a start/busy/done handshake.
- Sits beside seq_mult in the arithmetic datapath. Benches use it to close the loop: (quot*divisor)+rem == dividend.

Parameters:
- WIDTH, 4, bit width of dividend, divisor, quotient and remainder (WIDTH >= 2).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled on rising clk; accepted only in IDLE or DONE state.
- dividend  input  WIDTH  unsigned dividend; captured on the accepting edge.
- divisor  input  WIDTH  unsigned divisor; captured on the accepting edge.
- busy  output  1  high while an accepted division is iterating.
- done  output  1  one-cycle pulse; quot/rem/dz are valid from this cycle on.
- quot  output  WIDTH  quotient.
- rem  output  WIDTH  remainder.
- dz  output  1  divide-by-zero flag for the last completed operation.

Behaviour:
- Reset: rst_n low immediately forces state=IDLE and busy=done=dz=0, quot=rem=0, iteration counter=0. No clock is needed.
- States:
  - IDLE: waiting for start.
  - RUN: iterating.
  - DONE: one cycle, done=1.
- Accepting edge (call it edge 0), taken when start=1 in IDLE or DONE:
  - Latch dividend into a working quotient shift register and divisor into a divisor register.
  - Clear the partial remainder (WIDTH+1 bits).
  - counter=0, state=RUN, busy=1.
- Each edge in RUN:
  - Shift {partial remainder, working quotient} left by 1.
  - Trial = partial remainder - divisor.
  - If trial is non-negative: partial remainder = trial and quotient LSB = 1. Otherwise restore and quotient LSB = 0.
  - counter++.
- Edge WIDTH performs the final iteration and transitions to DONE:
  - busy=0, done=1.
  - quot/rem are loaded from the working registers.
  - dz = (latched divisor == 0).
- Fixed latency: done is high in the cycle after edge WIDTH, i.e. WIDTH cycles after acceptance. The latency is independent of operand values.
- DONE lasts exactly one cycle. The next edge goes to IDLE (done=0), unless start=1, in which case a new operation is accepted: RUN, busy=1, done=0. This permits back-to-back operations every WIDTH+1 cycles.
- quot, rem and dz hold their values until the next completion. They do not change while a later operation runs.
- start while busy=1 is ignored. Operand changes during RUN have no effect.
- Divide by zero: there is no special path. The restoring algorithm naturally yields quot = all ones and rem = dividend. dz=1 with the normal latency.
- Arithmetic: the partial remainder is WIDTH+1 bits so the trial subtraction sign is exact. Final rem is its low WIDTH bits and is always < divisor when divisor != 0.
- rst_n asserted mid-RUN: the operation is aborted with no done pulse, and outputs return to reset values. The first start after deassertion is accepted normally.
- busy and done are never high in the same cycle.

Test Plan (WIDTH=4):
- Reset, then start with dividend=13, divisor=3 -> busy=1 for 4 cycles, done pulses once in the 5th cycle after acceptance, quot=4, rem=1, dz=0; values hold until the next completion.
- Boundary operands: 15/1 -> quot=15, rem=0. 2/5 -> quot=0, rem=2. 0/7 -> quot=0, rem=0. 15/15 -> quot=1, rem=0.
- Divide by zero: 7/0 -> quot=15, rem=7, dz=1 at the same latency. The next operation 6/2 -> quot=3, rem=0, dz=0.
- Start held high continuously with 9/2 -> accepted again in each DONE cycle; done pulses every 5 cycles; quot=4, rem=1 each time. A start pulse with 15/1 mid-RUN is ignored and the result stays 4/1.
- Reset mid-operation: accept 13/3, assert rst_n low after 2 cycles -> busy, done, quot, rem and dz are 0 immediately with no clock; no done pulse. After release, 10/3 -> quot=3, rem=1.
- Exhaustive sweep of all 256 operand pairs, with seq_mult as cross-check -> for divisor != 0, quot*divisor+rem == dividend and rem < divisor; for divisor == 0, dz=1.

Source files
------------

// File: rtl/seq_div.sv
// seq_div: multi-cycle unsigned restoring divider, one quotient bit per clock,
// MSB first, with a start/busy/done handshake. Latency is fixed at WIDTH
// cycles from acceptance to the done pulse, regardless of operand values.
module seq_div #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quot,
    output logic [WIDTH-1:0] rem,
    output logic             dz
);

    // Counter must hold WIDTH itself after the final increment.
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q,   cnt_d;
    logic [WIDTH:0]   pr_q,    pr_d;     // partial remainder, one extra bit for the trial sign
    logic [WIDTH-1:0] wq_q,    wq_d;     // working quotient / dividend shift register
    logic [WIDTH-1:0] dvs_q,   dvs_d;    // divisor latched at acceptance
    logic [WIDTH-1:0] quot_q,  quot_d;
    logic [WIDTH-1:0] rem_q,   rem_d;
    logic             dz_q,    dz_d;

    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;
    logic             last_iter;
    logic             accept;

    // The partial remainder is always below 2^WIDTH after a restore step, so
    // its top bit never feeds the next shift; it exists only as the trial sign.
    logic pr_msb_unused;
    assign pr_msb_unused = pr_q[WIDTH];

    // One restoring step: shift in the next dividend bit and trial-subtract.
    always_comb begin
        shifted   = {pr_q[WIDTH-1:0], wq_q[WIDTH-1]};
        trial     = shifted - {1'b0, dvs_q};
        last_iter = (cnt_q == CW'(WIDTH - 1));
        accept    = start && ((state_q == S_IDLE) || (state_q == S_DONE));
    end

    // Next-state logic: IDLE -> RUN on start, RUN -> DONE on the last step,
    // DONE lasts one cycle and may immediately accept a new operation.
    always_comb begin
        // NOTE: assign a default to every combinational output first; a path
        // that leaves a variable unassigned infers a latch.
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_RUN;
            S_RUN:   if (last_iter) state_d = S_DONE;
            S_DONE:  state_d = start ? S_RUN : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath next-state: load operands on acceptance, iterate in RUN and
    // publish the result on the final step; results hold otherwise.
    always_comb begin
        cnt_d  = cnt_q;
        pr_d   = pr_q;
        wq_d   = wq_q;
        dvs_d  = dvs_q;
        quot_d = quot_q;
        rem_d  = rem_q;
        dz_d   = dz_q;
        if (accept) begin
            wq_d  = dividend;
            dvs_d = divisor;
            pr_d  = '0;
            cnt_d = '0;
        end else if (state_q == S_RUN) begin
            pr_d  = trial[WIDTH] ? shifted : trial;
            wq_d  = {wq_q[WIDTH-2:0], ~trial[WIDTH]};
            cnt_d = cnt_q + CW'(1);
            if (last_iter) begin
                quot_d = wq_d;
                rem_d  = pr_d[WIDTH-1:0];
                dz_d   = (dvs_q == '0);
            end
        end
    end

    // State and datapath registers, all cleared by the asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values of the others.
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            pr_q    <= '0;
            wq_q    <= '0;
            dvs_q   <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pr_q    <= pr_d;
            wq_q    <= wq_d;
            dvs_q   <= dvs_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dz_q    <= dz_d;
        end
    end

    // Handshake flags decode straight from the state, so they are mutually
    // exclusive and clear immediately on reset.
    always_comb begin
        busy = (state_q == S_RUN);
        done = (state_q == S_DONE);
        quot = quot_q;
        rem  = rem_q;
        dz   = dz_q;
    end

endmodule

// File: tb/tb_seq_div.sv
// tb_seq_div: directed self-checking bench for seq_div at WIDTH=4.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_seq_div;

    localparam int W = 4;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         busy;
    logic         done;
    logic [W-1:0] quot;
    logic [W-1:0] rem;
    logic         dz;

    int errors = 0;
    int checks = 0;

    seq_div #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .dividend (dividend),
        .divisor  (divisor),
        .busy     (busy),
        .done     (done),
        .quot     (quot),
        .rem      (rem),
        .dz       (dz)
    );

    // 10 ns clock, first rising edge at 5 ns.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Issue one operation from IDLE/DONE and follow it to its done cycle.
    // Operands are scrambled during RUN to show they are not re-sampled; with
    // poke set, a one-cycle start with 15/1 is raised mid-RUN. Returns at the
    // falling edge of the done cycle.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input bit poke);
        logic [W-1:0] q0, r0;
        @(negedge clk);
        check("idle_after_done", {31'd0, done}, 32'd0);
        q0 = quot;
        r0 = rem;
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        dividend = ~a;
        divisor  = ~b;
        for (int i = 0; i < W; i++) begin
            check("busy_run", {31'd0, busy}, 32'd1);
            check("no_done_run", {31'd0, done}, 32'd0);
            check("quot_hold", {28'd0, quot}, {28'd0, q0});
            check("rem_hold", {28'd0, rem}, {28'd0, r0});
            if (poke && i == 1) begin
                start    = 1'b1;
                dividend = 4'd15;
                divisor  = 4'd1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        check("done_pulse", {31'd0, done}, 32'd1);
        check("busy_clear", {31'd0, busy}, 32'd0);
    endtask

    task automatic expect_result(input string tag, input int q, input int r, input int z);
        check({tag, "_quot"}, {28'd0, quot}, q);
        check({tag, "_rem"}, {28'd0, rem}, r);
        check({tag, "_dz"}, {31'd0, dz}, z);
    endtask

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;

        // Reset state, before any clock edge.
        #3;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_quot", {28'd0, quot}, 32'd0);
        check("rst_rem", {28'd0, rem}, 32'd0);
        check("rst_dz", {31'd0, dz}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic operation.
        run_op(4'd13, 4'd3, 1'b0);
        expect_result("d13_3", 4, 1, 0);

        // Boundary operands.
        run_op(4'd15, 4'd1, 1'b0);
        expect_result("d15_1", 15, 0, 0);
        run_op(4'd2, 4'd5, 1'b0);
        expect_result("d2_5", 0, 2, 0);
        run_op(4'd0, 4'd7, 1'b0);
        expect_result("d0_7", 0, 0, 0);
        run_op(4'd15, 4'd15, 1'b0);
        expect_result("d15_15", 1, 0, 0);

        // Divide by zero, then recovery.
        run_op(4'd7, 4'd0, 1'b0);
        expect_result("d7_0", 15, 7, 1);
        run_op(4'd6, 4'd2, 1'b0);
        expect_result("d6_2", 3, 0, 0);

        // Start held high: re-accepted in each DONE cycle, done every 5 cycles.
        // Operands are disturbed mid-RUN of the second pass and restored.
        @(negedge clk);
        dividend = 4'd9;
        divisor  = 4'd2;
        start    = 1'b1;
        for (int k = 1; k <= 15; k++) begin
            @(negedge clk);
            check("held_done", {31'd0, done}, (k % 5 == 0) ? 32'd1 : 32'd0);
            check("held_busy", {31'd0, busy}, (k % 5 == 0) ? 32'd0 : 32'd1);
            if (k % 5 == 0) expect_result("held_9_2", 4, 1, 0);
            if (k == 7) begin
                dividend = 4'd15;
                divisor  = 4'd1;
            end
            if (k == 8) begin
                dividend = 4'd9;
                divisor  = 4'd2;
            end
            if (k == 15) start = 1'b0;
        end

        // Start pulse mid-RUN is ignored.
        run_op(4'd9, 4'd2, 1'b1);
        expect_result("poke_9_2", 4, 1, 0);
        @(negedge clk);
        check("poke_no_restart", {31'd0, busy}, 32'd0);

        // Reset mid-operation: outputs clear without a clock, no done pulse.
        dividend = 4'd13;
        divisor  = 4'd3;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        check("abort_quot", {28'd0, quot}, 32'd0);
        check("abort_rem", {28'd0, rem}, 32'd0);
        check("abort_dz", {31'd0, dz}, 32'd0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("abort_no_done", {31'd0, done}, 32'd0);
        end
        rst_n = 1'b1;
        run_op(4'd10, 4'd3, 1'b0);
        expect_result("d10_3", 3, 1, 0);

        // Exhaustive sweep, closing the loop with quot*divisor+rem.
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                run_op(W'(a), W'(b), 1'b0);
                if (b != 0) begin
                    check("sweep_recon", 32'(quot) * 32'(b) + 32'(rem), a);
                    check("sweep_rem_lt", {31'd0, (32'(rem) < 32'(b))}, 32'd1);
                    check("sweep_dz0", {31'd0, dz}, 32'd0);
                end else begin
                    check("sweep_dz1", {31'd0, dz}, 32'd1);
                    check("sweep_dz_quot", {28'd0, quot}, 32'd15);
                    check("sweep_dz_rem", {28'd0, rem}, a);
                end
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
